// File: rtl/entropy_collector_pkg.sv
// entropy_collector_pkg: shared defaults and pair-FSM state type for the entropy collector
package entropy_collector_pkg;
  localparam int TRNG_WORD_W = 32;
  localparam int TRNG_SAMPLE_DIV = 8;
  localparam int TRNG_REP_LIMIT = 32;
  typedef enum logic {EMPTY, HAVE_FIRST} pair_e;
endpackage

// File: rtl/entropy_collector_if.sv
// entropy_collector_if: word output bus; master drives out_data/out_valid, slave drives out_ready
interface entropy_collector_if import entropy_collector_pkg::*; #(parameter int WORD_W = TRNG_WORD_W);
  logic [WORD_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (output out_data, output out_valid, input out_ready);
  modport slave (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/entropy_collector_vn_debias.sv
// entropy_collector_vn_debias: von Neumann pair debiaser; ports clk, rst, clr_i, strobe_i, bit_i -> emit_o, val_o
module entropy_collector_vn_debias import entropy_collector_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic strobe_i,
  input  logic bit_i,
  output logic emit_o,
  output logic val_o
);
  pair_e state_q, state_d;
  logic first_q, first_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= EMPTY;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    emit_o = 1'b0;
    val_o = first_q;
    if (clr_i) state_d = EMPTY;
    else if (strobe_i) begin
      state_d = state_q == EMPTY ? HAVE_FIRST : EMPTY;
      first_d = state_q == EMPTY ? bit_i : first_q;
      emit_o = state_q == HAVE_FIRST && first_q != bit_i;
    end
  end
endmodule

// File: rtl/entropy_collector.sv
// entropy_collector: sync + sample strobe + repetition test + VN debias + word packer; ports clk, rst, raw_bit, en, health_fail, bus (master: out_data, out_valid, out_ready)
module entropy_collector import entropy_collector_pkg::*; #(
  parameter int WORD_W = TRNG_WORD_W,
  parameter int SAMPLE_DIV = TRNG_SAMPLE_DIV,
  parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_bit,
  input  logic en,
  output logic health_fail,
  entropy_collector_if.master bus
);
  localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int BW = $clog2(WORD_W);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic last_q, last_d, hf_q, hf_d, full_q, full_d, valid_q, valid_d;
  logic [WORD_W-1:0] shift_q, shift_d, data_q, data_d, word;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic strobe, sample, emit, emit_val, hs, free;
  assign sample = sync_q[1];
  entropy_collector_vn_debias u_vn (
    .clk(clk), .rst(rst), .clr_i(hf_q || !en), .strobe_i(strobe), .bit_i(sample),
    .emit_o(emit), .val_o(emit_val)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      rep_q <= '0;
      last_q <= 1'b0;
      hf_q <= 1'b0;
      shift_q <= '0;
      bit_cnt_q <= '0;
      full_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_bit};
      cnt_q <= cnt_d;
      rep_q <= rep_d;
      last_q <= last_d;
      hf_q <= hf_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      full_q <= full_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  always_comb begin
    strobe = en && cnt_q == CW'(SAMPLE_DIV - 1);
    cnt_d = (!en || strobe) ? '0 : cnt_q + 1'b1;
    // rep_q==0 only before the first strobe, so that strobe always restarts the run at 1
    rep_d = !strobe ? rep_q :
            (sample == last_q && rep_q != '0) ? (rep_q == RW'(REP_LIMIT) ? rep_q : rep_q + 1'b1) : RW'(1);
    last_d = strobe ? sample : last_q;
    hf_d = hf_q || rep_d == RW'(REP_LIMIT);
    hs = valid_q && bus.out_ready;
    free = !valid_q || hs;
    word = shift_q;
    word[bit_cnt_q] = emit_val;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    full_d = full_q;
    data_d = data_q;
    valid_d = valid_q && !hs;
    if (hf_q) begin
      shift_d = '0;
      bit_cnt_d = '0;
      full_d = 1'b0;
      valid_d = 1'b0;
    end else if (full_q) begin
      // a parked word blocks new bits until the output register frees up
      if (free) begin
        data_d = shift_q;
        valid_d = 1'b1;
        shift_d = '0;
        bit_cnt_d = '0;
        full_d = 1'b0;
      end
    end else if (emit) begin
      if (bit_cnt_q == BW'(WORD_W - 1)) begin
        data_d = free ? word : data_q;
        valid_d = free ? 1'b1 : valid_d;
        shift_d = free ? '0 : word;
        bit_cnt_d = free ? '0 : bit_cnt_q;
        full_d = !free;
      end else begin
        shift_d = word;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end
  assign bus.out_data = data_q;
  assign bus.out_valid = valid_q;
  assign health_fail = hf_q;
endmodule

// File: tb/tb_entropy_collector.sv
// tb_entropy_collector: directed self-checking bench for entropy_collector (DIV=4 and DIV=1 instances)
module tb_entropy_collector;
  logic clk, rst, raw, en, raw1, en1, hf, hf1;
  int total, bad, nw, nw1, vcyc;
  logic [7:0] lastw, lastw1;
  entropy_collector_if #(.WORD_W(8)) bus();
  entropy_collector_if #(.WORD_W(8)) bus1();
  entropy_collector #(.WORD_W(8), .SAMPLE_DIV(4), .REP_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .raw_bit(raw), .en(en), .health_fail(hf), .bus(bus)
  );
  entropy_collector #(.WORD_W(8), .SAMPLE_DIV(1), .REP_LIMIT(16)) dut1 (
    .clk(clk), .rst(rst), .raw_bit(raw1), .en(en1), .health_fail(hf1), .bus(bus1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    nw = 0;
    nw1 = 0;
    vcyc = 0;
    lastw = '0;
    lastw1 = '0;
  end
  always @(posedge clk) begin
    if (bus.out_valid) vcyc++;
    if (bus.out_valid && bus.out_ready) begin
      nw++;
      lastw = bus.out_data;
    end
    if (bus1.out_valid && bus1.out_ready) begin
      nw1++;
      lastw1 = bus1.out_data;
    end
  end
  task automatic pb(input logic b);
    raw = b;
    en = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      pb(w[i]);
      pb(!w[i]);
    end
  endtask
  task automatic idle();
    en = 1'b0;
    raw = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_reset();
    en = 1'b0;
    raw = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
    total++; if (hf !== 1'b0) begin bad++; $display("FAIL reset_hf got=%b exp=0", hf); end
  endtask
  task automatic test_alternate();
    int n0, v0;
    do_reset();
    bus.out_ready = 1'b1;
    n0 = nw;
    v0 = vcyc;
    send_word(8'hFF);
    send_word(8'hFF);
    idle();
    total++; if (nw - n0 !== 2) begin bad++; $display("FAIL alt_words got=%0d exp=2", nw - n0); end
    total++; if (vcyc - v0 !== 2) begin bad++; $display("FAIL alt_valid_cycles got=%0d exp=2", vcyc - v0); end
    total++; if (lastw !== 8'hFF) begin bad++; $display("FAIL alt_data got=%h exp=ff", lastw); end
    total++; if (hf !== 1'b0) begin bad++; $display("FAIL alt_hf got=%b exp=0", hf); end
  endtask
  task automatic test_discard();
    int n0;
    logic [3:0] k;
    do_reset();
    bus.out_ready = 1'b1;
    n0 = nw;
    for (int i = 0; i < 8; i++) begin
      k = 4'(i);
      pb(1'b0); pb(1'b1);
      pb(k[0]); pb(k[0]);
    end
    idle();
    total++; if (nw - n0 !== 1) begin bad++; $display("FAIL discard_words got=%0d exp=1", nw - n0); end
    total++; if (lastw !== 8'h00) begin bad++; $display("FAIL discard_data got=%h exp=00", lastw); end
  endtask
  task automatic test_health();
    int n0;
    do_reset();
    bus.out_ready = 1'b1;
    n0 = nw;
    repeat (15) pb(1'b1);
    total++; if (hf !== 1'b0) begin bad++; $display("FAIL hf_early got=%b exp=0", hf); end
    pb(1'b1);
    total++; if (hf !== 1'b1) begin bad++; $display("FAIL hf_set got=%b exp=1", hf); end
    send_word(8'hFF);
    idle();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hf_valid got=%b exp=0", bus.out_valid); end
    total++; if (nw - n0 !== 0) begin bad++; $display("FAIL hf_words got=%0d exp=0", nw - n0); end
    total++; if (hf !== 1'b1) begin bad++; $display("FAIL hf_sticky got=%b exp=1", hf); end
    do_reset();
    total++; if (hf !== 1'b0) begin bad++; $display("FAIL hf_cleared got=%b exp=0", hf); end
  endtask
  task automatic test_backpressure();
    int n0;
    do_reset();
    bus.out_ready = 1'b0;
    n0 = nw;
    send_word(8'hFF);
    send_word(8'hA5);
    send_word(8'h3C);
    idle();
    total++; if (bus.out_data !== 8'hFF) begin bad++; $display("FAIL bp_hold_data got=%h exp=ff", bus.out_data); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", bus.out_valid); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.out_data !== 8'hA5) begin bad++; $display("FAIL bp_word2 got=%h exp=a5", bus.out_data); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_word2_valid got=%b exp=1", bus.out_valid); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_word3_dropped got=%b exp=0", bus.out_valid); end
    total++; if (nw - n0 !== 2 || lastw !== 8'hA5) begin bad++; $display("FAIL bp_accepted got=%0d/%h exp=2/a5", nw - n0, lastw); end
  endtask
  task automatic test_async_reset();
    int n0;
    do_reset();
    bus.out_ready = 1'b0;
    send_word(8'hFF);
    for (int i = 0; i < 5; i++) begin
      pb(1'b1); pb(1'b0);
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL ar_data got=%h exp=00", bus.out_data); end
    en = 1'b0;
    raw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    n0 = nw;
    send_word(8'h5A);
    idle();
    total++; if (nw - n0 !== 1) begin bad++; $display("FAIL ar_words got=%0d exp=1", nw - n0); end
    total++; if (lastw !== 8'h5A) begin bad++; $display("FAIL ar_data_after got=%h exp=5a", lastw); end
  endtask
  task automatic test_en_drop();
    int n0;
    do_reset();
    bus.out_ready = 1'b1;
    n0 = nw;
    pb(1'b1);
    idle();
    repeat (3) @(negedge clk);
    send_word(8'h0F);
    idle();
    total++; if (nw - n0 !== 1) begin bad++; $display("FAIL en_drop_words got=%0d exp=1", nw - n0); end
    total++; if (lastw !== 8'h0F) begin bad++; $display("FAIL en_drop_data got=%h exp=0f", lastw); end
  endtask
  task automatic test_div1();
    int n0;
    logic [7:0] w;
    do_reset();
    bus1.out_ready = 1'b1;
    raw1 = 1'b0;
    repeat (3) @(negedge clk);
    n0 = nw1;
    w = 8'h3C;
    en1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raw1 = i[0] ? !w[i/2] : w[i/2];
      @(negedge clk);
    end
    raw1 = 1'b0;
    repeat (2) @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    total++; if (nw1 - n0 !== 1) begin bad++; $display("FAIL div1_words got=%0d exp=1", nw1 - n0); end
    total++; if (lastw1 !== 8'h3C) begin bad++; $display("FAIL div1_data got=%h exp=3c", lastw1); end
  endtask
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 1'b0;
    raw = 1'b0;
    en1 = 1'b0;
    raw1 = 1'b0;
    bus.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_alternate();
    test_discard();
    test_health();
    test_backpressure();
    test_async_reset();
    test_en_drop();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
